// File: rtl/median3x3_window_if.sv
// Pixel-column input and median output bundle between the row line buffer,
// the 3x3 median window and the output writer.
interface median3x3_window_if #(
  parameter int Datawidth = 8
);
  logic [Datawidth-1:0] Row0;
  logic [Datawidth-1:0] Row1;
  logic [Datawidth-1:0] Row2;
  logic                 In_Valid;
  logic                 SOF;
  logic [Datawidth-1:0] Median;
  logic                 Out_Valid;
  logic                 Frame_Done;

  modport master (
    output Row0, Row1, Row2, In_Valid, SOF,
    input  Median, Out_Valid, Frame_Done
  );

  modport slave (
    input  Row0, Row1, Row2, In_Valid, SOF,
    output Median, Out_Valid, Frame_Done
  );
endinterface

// File: rtl/median3x3_window.sv
// 3x3 sliding-window median: assembles the window from three row taps and
// reduces it through a 3-stage sorting network, emitting one median per interior pixel.
module median3x3_window #(
  parameter int IMG_Width  = 256,
  parameter int IMG_Height = 256,
  parameter int Datawidth  = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  median3x3_window_if.slave io
);

  localparam int CW = $clog2(IMG_Width);
  localparam int RW = $clog2(IMG_Height);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_Width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_Height - 1);

  typedef logic [Datawidth-1:0] pix_t;
  typedef struct packed {
    pix_t lo;
    pix_t mid;
    pix_t hi;
  } sort3_t;

  // Three compare-exchanges; equal values never swap, so ties are deterministic.
  function automatic sort3_t sort3(input pix_t a, input pix_t b, input pix_t c);
    pix_t   x, y, z, t;
    sort3_t r;
    x = a;
    y = b;
    z = c;
    if (x > y) begin t = x; x = y; y = t; end
    if (y > z) begin t = y; y = z; z = t; end
    if (x > y) begin t = x; x = y; y = t; end
    r.lo  = x;
    r.mid = y;
    r.hi  = z;
    return r;
  endfunction

  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    sort3_t s;
    s = sort3(a, b, c);
    return s.mid;
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    pix_t t;
    t = (a > b) ? a : b;
    return (t > c) ? t : c;
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    pix_t t;
    t = (a < b) ? a : b;
    return (t < c) ? t : c;
  endfunction

  // ---------------------------------------------------------------------------
  // Position tagging
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col, tag_col, col_nxt;
  logic [RW-1:0] row, tag_row, row_nxt;
  logic          win_v, last_v;

  // NOTE: every combinational output gets a default first, so no path can hold a stale value and infer a latch.
  always_comb begin
    tag_col = io.SOF ? '0 : col;
    tag_row = io.SOF ? '0 : row;
    col_nxt = tag_col + CW'(1);
    row_nxt = tag_row;
    if (tag_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (tag_row == ROW_LAST) ? '0 : tag_row + RW'(1);
    end
    win_v  = (tag_col >= CW'(2)) && (tag_row >= RW'(2));
    last_v = (tag_col == COL_LAST) && (tag_row == ROW_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      col <= '0;
      row <= '0;
    end else if (io.In_Valid) begin
      col <= col_nxt;
      row <= row_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Window: win[r][2] is the newest column, win[r][0] the oldest
  // ---------------------------------------------------------------------------
  pix_t win [3][3];
  logic v0, l0;

  // NOTE: the window is a small register array, not a RAM, so it is cleared by reset like any other flop.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int r = 0; r < 3; r++) begin
        for (int a = 0; a < 3; a++) begin
          win[r][a] <= '0;
        end
      end
      v0 <= 1'b0;
      l0 <= 1'b0;
    end else begin
      v0 <= io.In_Valid & win_v;
      l0 <= io.In_Valid & last_v;
      if (io.In_Valid) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= io.Row0;
        win[1][2] <= io.Row1;
        win[2][2] <= io.Row2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1: vertical sort of each window column
  // ---------------------------------------------------------------------------
  sort3_t s1 [3];
  logic   v1, l1;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int c = 0; c < 3; c++) begin
        s1[c] <= '0;
      end
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        s1[c] <= sort3(win[0][c], win[1][c], win[2][c]);
      end
      v1 <= v0;
      l1 <= l0;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: the median is bounded by the largest low, middle mid and smallest high
  // ---------------------------------------------------------------------------
  pix_t s2_lo, s2_mid, s2_hi;
  logic v2, l2;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      s2_lo  <= '0;
      s2_mid <= '0;
      s2_hi  <= '0;
      v2     <= 1'b0;
      l2     <= 1'b0;
    end else begin
      s2_lo  <= max3(s1[0].lo,  s1[1].lo,  s1[2].lo);
      s2_mid <= med3(s1[0].mid, s1[1].mid, s1[2].mid);
      s2_hi  <= min3(s1[0].hi,  s1[1].hi,  s1[2].hi);
      v2     <= v1;
      l2     <= l1;
    end
  end

  // ---------------------------------------------------------------------------
  // S3: final median; value holds between valid results
  // ---------------------------------------------------------------------------
  pix_t median_q;
  logic out_valid_q, frame_done_q;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      median_q     <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (v2) begin
        median_q <= med3(s2_lo, s2_mid, s2_hi);
      end
      out_valid_q  <= v2;
      frame_done_q <= v2 & l2;
    end
  end

  assign io.Median     = median_q;
  assign io.Out_Valid  = out_valid_q;
  assign io.Frame_Done = frame_done_q;

endmodule

// File: tb/tb_median3x3_window.sv
// Scoreboard bench for median3x3_window: a 3x3 and an 8x6 instance are fed
// pixel streams; a reference model queues expected medians, a monitor pops and compares.
module tb_median3x3_window;

  localparam int W0 = 3;
  localparam int H0 = 3;
  localparam int W1 = 8;
  localparam int H1 = 6;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  median3x3_window_if #(.Datawidth(8)) bus0 ();
  median3x3_window_if #(.Datawidth(8)) bus1 ();

  median3x3_window #(.IMG_Width(W0), .IMG_Height(H0), .Datawidth(8)) dut0 (
    .CLK(clk), .CLR(clr), .io(bus0)
  );
  median3x3_window #(.IMG_Width(W1), .IMG_Height(H1), .Datawidth(8)) dut1 (
    .CLK(clk), .CLR(clr), .io(bus1)
  );

  typedef struct {
    int med;
    bit last;
    int cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   lin      [2];
  int   hist     [2][3][3];
  int   out_cnt  [2];
  int   done_cnt [2];
  int   last_med [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Median of the nine window samples: the value with at most four smaller
  // and at least five smaller-or-equal samples.
  function automatic int median9(input int d);
    int v [9];
    for (int r = 0; r < 3; r++)
      for (int a = 0; a < 3; a++)
        v[r*3 + a] = hist[d][r][a];
    for (int i = 0; i < 9; i++) begin
      int lt = 0;
      int le = 0;
      for (int j = 0; j < 9; j++) begin
        if (v[j] <  v[i]) lt++;
        if (v[j] <= v[i]) le++;
      end
      if (lt <= 4 && le >= 5) return v[i];
    end
    return -1;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      lin[d]      = 0;
      last_med[d] = 0;
      for (int r = 0; r < 3; r++)
        for (int a = 0; a < 3; a++)
          hist[d][r][a] = 0;
    end
  endtask

  // Reference model for one accepted pixel; position is a linear frame index.
  task automatic model_accept(input int d, input int a, input int b, input int c, input bit sof);
    int   w, h, tc, tr;
    exp_t e;
    w = (d == 0) ? W0 : W1;
    h = (d == 0) ? H0 : H1;
    if (sof) lin[d] = 0;
    tc = lin[d] % w;
    tr = lin[d] / w;
    lin[d] = (lin[d] + 1) % (w * h);
    for (int r = 0; r < 3; r++) begin
      hist[d][r][0] = hist[d][r][1];
      hist[d][r][1] = hist[d][r][2];
    end
    hist[d][0][2] = a;
    hist[d][1][2] = b;
    hist[d][2][2] = c;
    if (tc >= 2 && tr >= 2) begin
      e.med  = median9(d);
      e.last = (tc == w - 1) && (tr == h - 1);
      e.cyc  = cyc + 1 + 3;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic send(input int d, input int a, input int b, input int c, input bit sof);
    @(negedge clk);
    bus0.In_Valid = 1'b0;
    bus1.In_Valid = 1'b0;
    bus0.SOF      = 1'b0;
    bus1.SOF      = 1'b0;
    if (d == 0) begin
      bus0.Row0 = 8'(a); bus0.Row1 = 8'(b); bus0.Row2 = 8'(c);
      bus0.In_Valid = 1'b1; bus0.SOF = sof;
    end else begin
      bus1.Row0 = 8'(a); bus1.Row1 = 8'(b); bus1.Row2 = 8'(c);
      bus1.In_Valid = 1'b1; bus1.SOF = sof;
    end
    model_accept(d, a, b, c, sof);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus0.In_Valid = 1'b0;
      bus1.In_Valid = 1'b0;
      bus0.SOF      = 1'b0;
      bus1.SOF      = 1'b0;
    end
  endtask

  task automatic mon(input int d, input logic ov, input logic fd, input logic [7:0] med);
    exp_t e;
    int   pending;
    pending = (d == 0) ? q0.size() : q1.size();
    if (ov === 1'b1) begin
      out_cnt[d]++;
      if (fd === 1'b1) done_cnt[d]++;
      check($sformatf("d%0d_output_expected", d), pending > 0, 1);
      if (pending > 0) begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("d%0d_median", d), med, e.med);
        check($sformatf("d%0d_frame_done", d), fd, e.last);
        check($sformatf("d%0d_latency_cycle", d), cyc, e.cyc);
      end
      last_med[d] = med;
    end else begin
      check($sformatf("d%0d_out_valid_known", d), ov, 0);
      check($sformatf("d%0d_frame_done_idle", d), fd, 0);
      check($sformatf("d%0d_median_hold", d), med, last_med[d]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (clr === 1'b1) begin
      mon(0, bus0.Out_Valid, bus0.Frame_Done, bus0.Median);
      mon(1, bus1.Out_Valid, bus1.Frame_Done, bus1.Median);
    end
  end

  task automatic expect_frame(input string name, input int d, input int o0, input int f0,
                              input int n_out, input int n_done);
    check({name, "_out_count"}, out_cnt[d] - o0, n_out);
    check({name, "_done_count"}, done_cnt[d] - f0, n_done);
    check({name, "_queue_drained"}, (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

  initial begin
    int o, f;
    bus0.Row0 = '0; bus0.Row1 = '0; bus0.Row2 = '0; bus0.In_Valid = 1'b0; bus0.SOF = 1'b0;
    bus1.Row0 = '0; bus1.Row1 = '0; bus1.Row2 = '0; bus1.In_Valid = 1'b0; bus1.SOF = 1'b0;
    for (int d = 0; d < 2; d++) begin
      out_cnt[d]  = 0;
      done_cnt[d] = 0;
    end
    model_reset();

    #1;
    check("rst_median0",    bus0.Median,     0);
    check("rst_out_valid0", bus0.Out_Valid,  0);
    check("rst_done0",      bus0.Frame_Done, 0);
    check("rst_median1",    bus1.Median,     0);
    check("rst_out_valid1", bus1.Out_Valid,  0);
    check("rst_done1",      bus1.Frame_Done, 0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    idle(2);

    // 3x3 frame whose only window is {1,2,3},{4,5,6},{7,8,9}
    o = out_cnt[0]; f = done_cnt[0];
    for (int k = 0; k < 9; k++) send(0, 1 + k % 3, 4 + k % 3, 7 + k % 3, k == 0);
    idle(6);
    expect_frame("ramp3x3", 0, o, f, 1, 1);
    check("ramp3x3_median_value", last_med[0], 5);

    // Same frame with a gap after every pixel
    o = out_cnt[0]; f = done_cnt[0];
    for (int k = 0; k < 9; k++) begin
      send(0, 1 + k % 3, 4 + k % 3, 7 + k % 3, k == 0);
      idle(1);
    end
    idle(6);
    expect_frame("gapped3x3", 0, o, f, 1, 1);
    check("gapped3x3_median_value", last_med[0], 5);

    // Eight 255 and one 0
    o = out_cnt[0]; f = done_cnt[0];
    for (int k = 0; k < 9; k++) send(0, 255, (k == 7) ? 0 : 255, 255, k == 0);
    idle(6);
    expect_frame("one_zero", 0, o, f, 1, 1);
    check("one_zero_median_value", last_med[0], 255);

    // Constant 200 over 8x6
    o = out_cnt[1]; f = done_cnt[1];
    for (int k = 0; k < W1 * H1; k++) send(1, 200, 200, 200, k == 0);
    idle(6);
    expect_frame("const200", 1, o, f, 24, 1);
    check("const200_median_value", last_med[1], 200);

    // Single impulse in a zero frame
    o = out_cnt[1]; f = done_cnt[1];
    for (int k = 0; k < W1 * H1; k++) send(1, 0, (k == 20) ? 255 : 0, 0, k == 0);
    idle(6);
    expect_frame("impulse", 1, o, f, 24, 1);
    check("impulse_median_value", last_med[1], 0);

    // Random pixels with random input gaps
    o = out_cnt[1]; f = done_cnt[1];
    for (int k = 0; k < W1 * H1; k++) begin
      send(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), k == 0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(6);
    expect_frame("random", 1, o, f, 24, 1);

    // Reset mid-frame with (2,2) and (3,2) still in flight
    for (int k = 0; k < 20; k++)
      send(1, int'($urandom_range(1, 255)), int'($urandom_range(1, 255)),
           int'($urandom_range(1, 255)), k == 0);
    @(posedge clk);
    #3;
    clr = 1'b0;
    #1;
    check("midrst_median",    bus1.Median,     0);
    check("midrst_out_valid", bus1.Out_Valid,  0);
    check("midrst_done",      bus1.Frame_Done, 0);
    check("midrst_median0",   bus0.Median,     0);
    model_reset();
    idle(3);
    clr = 1'b1;
    o = out_cnt[1]; f = done_cnt[1];
    idle(6);
    check("postrst_no_stale", out_cnt[1] - o, 0);
    for (int k = 0; k < W1 * H1; k++)
      send(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), k == 0);
    idle(6);
    expect_frame("postrst", 1, o, f, 24, 1);

    // SOF at (5,3): 9 old-frame outputs, then a full new frame
    o = out_cnt[1]; f = done_cnt[1];
    for (int k = 0; k < 29; k++)
      send(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), k == 0);
    for (int k = 0; k < W1 * H1; k++)
      send(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), k == 0);
    idle(6);
    expect_frame("late_sof", 1, o, f, 33, 1);

    check("final_q0_empty", q0.size(), 0);
    check("final_q1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/median3x3_window.md
Name: median3x3_window

Overview:
- Downstream stage of the row line buffer in the median-filter datapath.
- Consumes three vertically aligned row taps per accepted pixel and assembles a 3x3 window from them.
- Computes the window median through a 3-stage pipelined sorting network.
- Emits one median per interior pixel, with valid and end-of-frame flags, to the output writer.

Parameters:
- IMG_Width, 256, pixels per row; must be at least 3.
- IMG_Height, 256, rows per frame; must be at least 3.
- Datawidth, 8, bits per pixel.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  asynchronous active-low reset.
- Row0  in  Datawidth  tap of the oldest row (window top).
- Row1  in  Datawidth  tap of the middle row.
- Row2  in  Datawidth  tap of the newest row (window bottom).
- In_Valid  in  1  the Row0..2 column is valid and is accepted this edge.
- SOF  in  1  start of frame; sampled only while In_Valid=1.
- Median  out  Datawidth  median of the 3x3 window.
- Out_Valid  out  1  Median is valid this cycle.
- Frame_Done  out  1  one-cycle pulse together with the final median of a frame.

Behaviour:
- Reset (CLR=0, asynchronous):
  - col and row counters, window registers, all pipeline data and valid flags clear to 0.
  - Median=0, Out_Valid=0, Frame_Done=0.
  - Held until the first edge after CLR deasserts.
- Window shift: on an edge with In_Valid=1, each row's 3-deep shift register shifts and takes Row0/1/2 in the newest position. With In_Valid=0 the window holds.
- Position counters:
  - col is 0..IMG_Width-1; row is 0..IMG_Height-1; each is $clog2 wide.
  - Each accepted pixel is tagged with the current (col,row), then col increments.
  - At col=IMG_Width-1, col wraps to 0 and row increments.
  - At row=IMG_Height-1 and col=IMG_Width-1, both wrap to 0.
- SOF: when SOF=1 and In_Valid=1, the accepted pixel is tagged (0,0) and the counters continue from there. Window contents are not cleared; border masking excludes stale data. SOF with In_Valid=0 is ignored.
- Window validity: win_v=1 for an accepted pixel tagged col>=2 and row>=2.
  - win_v=0 for all other pixels. Borders produce no output; the output count per frame is (IMG_Width-2)*(IMG_Height-2).
  - last_v=1 when the tag is (IMG_Width-1, IMG_Height-1).
- Pipeline: it advances every cycle and has no backpressure. win_v and last_v travel alongside the data.
  - S1: sort each window column into lo/mid/hi using 3 compare-exchanges, registered.
  - S2: register three values: max of the three lo, median of the three mid, min of the three hi.
  - S3: register the median of the three S2 values into Median.
  - All compares are unsigned and Datawidth wide; ties are allowed and give a deterministic equal value.
- Latency:
  - Pixel accepted at edge N updates the window at N. Median and Out_Valid are registered at edge N+3.
  - Throughput is 1 pixel per cycle; gaps in In_Valid appear as gaps in Out_Valid.
- Median register: it updates only when the S3 valid flag is 1 and otherwise holds its last value. Out_Valid and Frame_Done are 0 on non-valid cycles.
- Frame_Done is asserted in the same cycle as the Out_Valid of the last_v pixel.
- Reset mid-frame: all in-flight results are discarded and no Out_Valid is emitted for them. Counters restart at (0,0) with the first accepted pixel.
- Out-of-order SOF mid-frame: the counters retag to (0,0) immediately. Pipeline entries already in flight complete unchanged.

Test Plan:
- Window rows {1,2,3},{4,5,6},{7,8,9}, IMG_Width=IMG_Height=3 -> exactly one Out_Valid with Median=5, Frame_Done=1 in the same cycle, 3 edges after the 9th accepted column.
- Constant 200 frame, IMG_Width=8, IMG_Height=6 -> exactly 24 Out_Valid pulses, all Median=200, one Frame_Done on the 24th; no Out_Valid while col<2 or row<2.
- Single 255 impulse in an all-zero frame -> every Median=0. Window of eight 255 and one 0 -> Median=255.
- In_Valid toggled 1,0,1,0 across a 3x3 frame -> outputs identical to the continuous run. Out_Valid gaps mirror the input gaps, and the median is unchanged.
- CLR pulsed low mid-frame with 2 results in flight -> Out_Valid/Median/Frame_Done go 0 asynchronously and no stale result appears afterward. The next frame with SOF gives the correct 24-output count.
- SOF asserted at col=5,row=3 of an 8x6 frame -> that pixel is treated as (0,0). The next 24 valid outputs follow the new frame tagging, and Frame_Done fires on the new frame's last pixel only.
